// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: counts lo->hi->lo a latched number of times per job,
// with pause, abort, start validation and a one-cycle done pulse.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       sweeps,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       sweeps_left
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] lo_q, hi_q, lo_nx, hi_nx;
    logic [WIDTH-1:0] count_nx, count_inc, count_dec;
    logic [3:0]       left_nx;
    logic             ud_nx, err_nx;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            up_down     <= 1'b1;
            err         <= 1'b0;
            sweeps_left <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            up_down     <= ud_nx;
            err         <= err_nx;
            sweeps_left <= left_nx;
            lo_q        <= lo_nx;
            hi_q        <= hi_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        ud_nx     = up_down;
        err_nx    = 1'b0;
        left_nx   = sweeps_left;
        lo_nx     = lo_q;
        hi_nx     = hi_q;
        count_inc = count + 1'b1;
        count_dec = count - 1'b1;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if ((lo < hi) && (sweeps != 4'd0)) begin
                        lo_nx    = lo;
                        hi_nx    = hi;
                        count_nx = lo;
                        ud_nx    = 1'b1;
                        left_nx  = sweeps;
                        state_nx = UP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    state_nx = IDLE;
                    count_nx = lo_q;
                    ud_nx    = 1'b1;
                    left_nx  = '0;
                end else if (!pause) begin
                    count_nx = count_inc;
                    if (count_inc == hi_q) begin
                        state_nx = DOWN;
                        ud_nx    = 1'b0;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_nx = IDLE;
                    count_nx = lo_q;
                    ud_nx    = 1'b1;
                    left_nx  = '0;
                end else if (!pause) begin
                    count_nx = count_dec;
                    // Reaching lo closes one full sweep; the last one ends the job.
                    if (count_dec == lo_q) begin
                        left_nx = sweeps_left - 1'b1;
                        if (sweeps_left > 4'd1) begin
                            state_nx = UP;
                            ud_nx    = 1'b1;
                        end else begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                count_nx = lo_q;
                left_nx  = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == UP) || (state == DOWN);
        done = (state == DONE);
    end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
- REQ-001 SHALL have parameter WIDTH, default 4, giving the count and bound width in bits.
- REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
- REQ-004 SHALL have port start  input  1  request to begin a sweep job; sampled in IDLE only.
- REQ-005 SHALL have port abort  input  1  terminates an active job.
- REQ-006 SHALL have port pause  input  1  freezes count and state while high.
- REQ-007 SHALL have port lo  input  WIDTH  lower sweep bound; latched on accepted start.
- REQ-008 SHALL have port hi  input  WIDTH  upper sweep bound; latched on accepted start.
- REQ-009 SHALL have port sweeps  input  4  number of full lo->hi->lo sweeps; latched on accepted start.
- REQ-010 SHALL have port count  output  WIDTH  current counter value (registered).
- REQ-011 SHALL have port up_down  output  1  1 = counting up, 0 = counting down (registered).
- REQ-012 SHALL have port busy  output  1  high in states UP and DOWN.
- REQ-013 SHALL have port done  output  1  one-cycle pulse on job completion.
- REQ-014 SHALL have port err  output  1  one-cycle pulse on a rejected start.
- REQ-015 SHALL have port sweeps_left  output  4  remaining sweeps, including the current one.

Function
- REQ-016 SHALL implement states IDLE, UP, DOWN and DONE; encoding is free.
- REQ-017 SHALL accept a start in IDLE when lo < hi (unsigned) and sweeps != 0: next cycle count=lo, up_down=1, sweeps_left=sweeps, state UP.
- REQ-018 SHALL reject a start in IDLE with lo >= hi or sweeps == 0: err=1 for the next cycle, state stays IDLE, count unchanged.
- REQ-019 SHALL ignore start in UP, DOWN and DONE; latched bounds and sweeps SHALL NOT change mid-job.
- REQ-020 SHALL, in UP without pause, set count <= count+1; when count+1 == hi, next state DOWN and up_down=0.
- REQ-021 SHALL, in DOWN without pause, set count <= count-1; when count-1 == lo, decrement sweeps_left; next state UP (up_down=1) if sweeps_left was >1, else DONE.
- REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, hold count=lo and sweeps_left=0, then go to IDLE.
- REQ-023 SHALL perform all arithmetic modulo 2^WIDTH; count never passes hi or lo, because the lo < hi check excludes wrap-around.
- REQ-024 SHALL, while pause=1 in UP/DOWN, hold count, up_down, sweeps_left and state; pause SHALL have no effect in IDLE or DONE.
- REQ-025 SHALL, on abort=1 in UP/DOWN, go to IDLE next cycle with count=lo(latched), up_down=1, sweeps_left=0, and no done pulse.
- REQ-026 SHALL apply precedence reset_n > abort > pause > normal stepping.
- REQ-027 SHALL permit a new start in the cycle after DONE (IDLE), giving back-to-back jobs with one idle cycle.
- REQ-028 SHALL produce, for lo=L, hi=H, sweeps=N, exactly 2*(H-L)*N counting edges from the UP entry to the DONE entry, with no pause.

Reset
- REQ-029 SHALL, with reset_n=0 at a rising edge, set state=IDLE, count=0, up_down=1, busy=0, done=0, err=0, sweeps_left=0, and clear latched lo/hi/sweeps to 0.
- REQ-030 SHALL give reset mid-job the same result as REQ-029, with no done pulse.

Verification
- REQ-031 SHALL cover basic job: lo=2, hi=5, sweeps=1, start for 1 cycle -> count 2,3,4,5,4,3,2 on consecutive cycles, then done=1 for one cycle, then IDLE.
- REQ-032 SHALL cover multi-sweep: lo=0, hi=15, sweeps=2 -> count 0..15..0..15..0, sweeps_left 2->1 at the first return to 0, then done after the second return.
- REQ-033 SHALL cover rejects: start with lo=7, hi=7 and with sweeps=0 -> err pulse each time, busy stays 0, count unchanged.
- REQ-034 SHALL cover pause and abort: pause held 3 cycles at count=4 in UP -> count stays 4 for 3 cycles then resumes 5; abort in DOWN -> IDLE, count=lo, no done.
- REQ-035 SHALL cover reset mid-job: reset_n=0 for 1 cycle during UP at count=3 -> all outputs at reset values next cycle; a start after release is accepted normally.
- REQ-036 SHALL cover simultaneous controls: abort=1 and pause=1 together -> abort wins; start held high through the job -> ignored until IDLE, then accepted on the cycle after done.
